// File: rtl/p405s_icu_pkg.sv
// Shared ICU definitions: line geometry and the fill-buffer state encoding.
package p405s_icu_pkg;

   localparam int ICU_LINE_WORDS = 8;
   localparam int ICU_IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DISCARD = 2'd3
   } icu_fill_state_e;

endpackage

// File: rtl/p405s_icu_fill_buf_ctl.sv
// Fill-buffer sequencer: state machine, beat counter, critical-word index
// adder and sticky error flag.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no fill in progress; waiting for fillReq
//  ST_FILL    | collecting beats, storing and bypassing each one
//  ST_WRITE   | line complete, presented to the array until ack or flush
//  ST_DISCARD | flushed mid-fill; swallowing the remaining beats silently
module p405s_icu_fill_buf_ctl
   import p405s_icu_pkg::*;
#(
   parameter int IDX_W = ICU_IDX_W
) (
   input  logic             CB,
   input  logic             resetN,
   input  logic             i_fill_req,
   input  logic [0:IDX_W-1] i_crit_idx,
   input  logic             i_beat_val,
   input  logic             i_beat_err,
   input  logic             i_flush,
   input  logic             i_wr_ack,
   output logic             o_busy,
   output logic             o_wr_en,
   output logic             o_byp_en,
   output logic [0:IDX_W-1] o_word_idx,
   output logic             o_line_val,
   output logic             o_line_err
);

   icu_fill_state_e  r_state;
   logic [0:IDX_W-1] r_crit_idx;
   logic [0:IDX_W-1] r_beat_cnt;
   logic             r_err_flag;

   icu_fill_state_e  w_state_nxt;
   logic [0:IDX_W-1] w_crit_nxt;
   logic [0:IDX_W-1] w_cnt_nxt;
   logic             w_err_nxt;
   logic             w_wr_en;
   logic             w_byp_en;
   logic             w_last_beat;

   assign w_last_beat = i_beat_val && (r_beat_cnt == '1);

   always_ff @(posedge CB) begin
      if (!resetN) begin
         r_state    <= ST_IDLE;
         r_crit_idx <= '0;
         r_beat_cnt <= '0;
         r_err_flag <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_crit_idx <= w_crit_nxt;
         r_beat_cnt <= w_cnt_nxt;
         r_err_flag <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_crit_nxt  = r_crit_idx;
      w_cnt_nxt   = r_beat_cnt;
      w_err_nxt   = r_err_flag;
      w_wr_en     = 1'b0;
      w_byp_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_fill_req) begin
               w_state_nxt = ST_FILL;
               w_crit_nxt  = i_crit_idx;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
            end
         end
         ST_FILL: begin
            if (i_beat_val) begin
               w_cnt_nxt = r_beat_cnt + IDX_W'(1);
               w_err_nxt = r_err_flag | i_beat_err;
               w_wr_en   = !i_flush;
               w_byp_en  = !i_flush;
            end
            if (i_flush)
               w_state_nxt = w_last_beat ? ST_IDLE : ST_DISCARD;
            else if (w_last_beat)
               w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            // flush wins over a simultaneous ack; both end in IDLE
            if (i_flush || i_wr_ack)
               w_state_nxt = ST_IDLE;
         end
         ST_DISCARD: begin
            if (i_beat_val) begin
               w_cnt_nxt = r_beat_cnt + IDX_W'(1);
               if (w_last_beat)
                  w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_wr_en    = w_wr_en;
   assign o_byp_en   = w_byp_en;
   assign o_word_idx = r_crit_idx + r_beat_cnt;
   assign o_line_val = (r_state == ST_WRITE);
   assign o_line_err = r_err_flag;

endmodule

// File: rtl/p405s_icu_fill_buf.sv
// ICU line-fill buffer: assembles a critical-word-first PLB line, bypasses
// each beat one cycle later, and presents the full line to the array.
module p405s_icu_fill_buf
   import p405s_icu_pkg::*;
#(
   parameter int WORDS_PER_LINE = ICU_LINE_WORDS,
   parameter int IDX_W          = ICU_IDX_W,
   parameter int DATA_W         = 32
) (
   input  logic                               CB,
   input  logic                               resetN,
   input  logic                               fillReq,
   input  logic [0:IDX_W-1]                   fillCritIdx,
   input  logic                               plbDataVal,
   input  logic [0:DATA_W-1]                  plbData,
   input  logic                               plbErr,
   input  logic                               flush,
   input  logic                               arrayWrAck,
   output logic                               fillBusy,
   output logic                               bypVal,
   output logic [0:DATA_W-1]                  bypData,
   output logic [0:IDX_W-1]                   bypIdx,
   output logic                               bypErr,
   output logic                               lineVal,
   output logic [0:WORDS_PER_LINE*DATA_W-1]   lineData,
   output logic                               lineErr
);

   logic             w_wr_en;
   logic             w_byp_en;
   logic [0:IDX_W-1] w_word_idx;
   logic             w_line_val;

   logic [0:DATA_W-1] r_words [0:WORDS_PER_LINE-1];
   logic              r_byp_val;
   logic [0:DATA_W-1] r_byp_data;
   logic [0:IDX_W-1]  r_byp_idx;
   logic              r_byp_err;

   p405s_icu_fill_buf_ctl #(
      .IDX_W (IDX_W)
   ) u_ctl (
      .CB         (CB),
      .resetN     (resetN),
      .i_fill_req (fillReq),
      .i_crit_idx (fillCritIdx),
      .i_beat_val (plbDataVal),
      .i_beat_err (plbErr),
      .i_flush    (flush),
      .i_wr_ack   (arrayWrAck),
      .o_busy     (fillBusy),
      .o_wr_en    (w_wr_en),
      .o_byp_en   (w_byp_en),
      .o_word_idx (w_word_idx),
      .o_line_val (w_line_val),
      .o_line_err (lineErr)
   );

   always_ff @(posedge CB) begin
      if (w_wr_en)
         r_words[w_word_idx] <= plbData;
   end

   always_ff @(posedge CB) begin
      if (!resetN) begin
         r_byp_val  <= 1'b0;
         r_byp_data <= '0;
         r_byp_idx  <= '0;
         r_byp_err  <= 1'b0;
      end else begin
         r_byp_val <= w_byp_en;
         if (w_byp_en) begin
            r_byp_data <= plbData;
            r_byp_idx  <= w_word_idx;
            r_byp_err  <= plbErr;
         end
      end
   end

   assign bypVal  = r_byp_val;
   assign bypData = r_byp_data;
   assign bypIdx  = r_byp_idx;
   assign bypErr  = r_byp_err;
   assign lineVal = w_line_val;

   // storage is never reset, so the line bus is gated to read 0 outside WRITE
   for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_line
      assign lineData[g*DATA_W +: DATA_W] = w_line_val ? r_words[g] : '0;
   end

endmodule
